ps2_scancode_decoder: RTL and testbench

Converts the synchronised PS/2 byte stream (`vld`/`data`, clk50 domain) into ASCII characters for the typewriter datapath. It sits directly downstream of the PS/2 receiver. It tracks scan-code set 2 prefixes (E0, F0), Shift and Caps Lock state, and buffers decoded characters in a small FIFO. The FIFO exposes a valid/ready interface to the character consumer.

---
 rtl/ps2_pkg.sv | 102 ++++++++++
 rtl/ps2_scancode_decoder_sync_fifo.sv | 56 +++++
 rtl/ps2_scancode_decoder.sv | 129 ++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code set 2 constants, decoder state type and the
// make-code to ASCII lookup used by the typewriter keyboard path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_E1     = 8'hE1;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;

  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;
  localparam logic [7:0] PS2_CAPS   = 8'h58;
  localparam logic [7:0] PS2_ENTER  = 8'h5A;
  localparam logic [7:0] PS2_SPACE  = 8'h29;
  localparam logic [7:0] PS2_BKSP   = 8'h66;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] BS = 8'h08;
  localparam logic [7:0] SP = 8'h20;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic       hit;
    logic [7:0] ch;
  } lookup_t;

  function automatic lookup_t scan2ascii(input logic [7:0] code,
                                         input logic       shift,
                                         input logic       caps);
    lookup_t    r;
    logic [7:0] letter;
    logic [7:0] plain;
    logic [7:0] shifted;
    r       = '0;
    letter  = '0;
    plain   = '0;
    shifted = '0;
    case (code)
      8'h1C: letter = "a";
      8'h32: letter = "b";
      8'h21: letter = "c";
      8'h23: letter = "d";
      8'h24: letter = "e";
      8'h2B: letter = "f";
      8'h34: letter = "g";
      8'h33: letter = "h";
      8'h43: letter = "i";
      8'h3B: letter = "j";
      8'h42: letter = "k";
      8'h4B: letter = "l";
      8'h3A: letter = "m";
      8'h31: letter = "n";
      8'h44: letter = "o";
      8'h4D: letter = "p";
      8'h15: letter = "q";
      8'h2D: letter = "r";
      8'h1B: letter = "s";
      8'h2C: letter = "t";
      8'h3C: letter = "u";
      8'h2A: letter = "v";
      8'h1D: letter = "w";
      8'h22: letter = "x";
      8'h35: letter = "y";
      8'h1A: letter = "z";
      default: letter = '0;
    endcase
    case (code)
      8'h16: begin plain = "1"; shifted = "!"; end
      8'h1E: begin plain = "2"; shifted = "@"; end
      8'h26: begin plain = "3"; shifted = "#"; end
      8'h25: begin plain = "4"; shifted = "$"; end
      8'h2E: begin plain = "5"; shifted = "%"; end
      8'h36: begin plain = "6"; shifted = "^"; end
      8'h3D: begin plain = "7"; shifted = "&"; end
      8'h3E: begin plain = "8"; shifted = "*"; end
      8'h46: begin plain = "9"; shifted = "("; end
      8'h45: begin plain = "0"; shifted = ")"; end
      PS2_SPACE: begin plain = SP; shifted = SP; end
      PS2_ENTER: begin plain = CR; shifted = CR; end
      PS2_BKSP:  begin plain = BS; shifted = BS; end
      default:   begin plain = '0; shifted = '0; end
    endcase
    if (letter != '0) begin
      r.hit = 1'b1;
      r.ch  = (shift ^ caps) ? (letter - 8'h20) : letter;
    end else if (plain != '0) begin
      r.hit = 1'b1;
      r.ch  = shift ? shifted : plain;
    end
    return r;
  endfunction

endpackage

// File: rtl/ps2_scancode_decoder_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle, otherwise flagged.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push_ok;

  assign o_valid   = (r_count != '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_pop     = i_pop & o_valid;
  assign w_push_ok = i_push & (~o_full | w_pop);
  assign o_drop    = i_push & ~w_push_ok;
  assign o_data    = o_valid ? r_mem[r_rptr] : '0;

  always_ff @(posedge clk50) begin
    if (w_push_ok) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop)     r_rptr <= r_rptr + AW'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to ASCII: prefix FSM, Shift/Caps tracking and an
// output FIFO with valid/ready towards the character consumer.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       reset,
  input  logic       clk50,
  input  logic       vld,
  input  logic [7:0] data,
  input  logic       out_rdy,
  output logic       out_vld,
  output logic [7:0] out_char,
  output logic       overflow,
  output logic       caps_led
);

  dec_state_t r_state, w_state_nx;
  logic       r_vld_d;
  logic       r_shift_l, w_shift_l_nx;
  logic       r_shift_r, w_shift_r_nx;
  logic       r_caps, w_caps_nx;
  logic       r_caps_held, w_caps_held_nx;
  logic       r_emit, w_emit_nx;
  logic [7:0] r_char, w_char_nx;
  logic       r_overflow;
  logic       w_accept;
  logic       w_drop;
  logic       w_full;
  lookup_t    w_lu;

  assign w_accept = vld & ~r_vld_d;
  assign w_lu     = scan2ascii(data, r_shift_l | r_shift_r, r_caps);

  always_ff @(posedge clk50 or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_vld_d     <= 1'b0;
      r_shift_l   <= 1'b0;
      r_shift_r   <= 1'b0;
      r_caps      <= 1'b0;
      r_caps_held <= 1'b0;
      r_emit      <= 1'b0;
      r_char      <= '0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_vld_d     <= vld;
      r_shift_l   <= w_shift_l_nx;
      r_shift_r   <= w_shift_r_nx;
      r_caps      <= w_caps_nx;
      r_caps_held <= w_caps_held_nx;
      r_emit      <= w_emit_nx;
      r_char      <= w_char_nx;
      r_overflow  <= w_drop;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_shift_l_nx   = r_shift_l;
    w_shift_r_nx   = r_shift_r;
    w_caps_nx      = r_caps;
    w_caps_held_nx = r_caps_held;
    w_emit_nx      = 1'b0;
    w_char_nx      = '0;
    if (w_accept) begin
      case (r_state)
        ST_IDLE: begin
          case (data)
            PS2_EXT: w_state_nx = ST_EXT;
            PS2_BRK: w_state_nx = ST_BRK;
            PS2_E1, PS2_BAT, PS2_ACK, PS2_RESEND, PS2_ECHO: w_state_nx = ST_IDLE;
            default: begin
              if (data == PS2_LSHIFT) w_shift_l_nx = 1'b1;
              if (data == PS2_RSHIFT) w_shift_r_nx = 1'b1;
              // Caps toggles only on the first make; typematic repeats are held off
              if (data == PS2_CAPS) begin
                if (!r_caps_held) w_caps_nx = ~r_caps;
                w_caps_held_nx = 1'b1;
              end
              w_emit_nx = w_lu.hit;
              w_char_nx = w_lu.hit ? w_lu.ch : '0;
            end
          endcase
        end
        ST_EXT: begin
          if (data == PS2_BRK) begin
            w_state_nx = ST_EXT_BRK;
          end else begin
            w_state_nx = ST_IDLE;
            if (data == PS2_ENTER) begin
              w_emit_nx = 1'b1;
              w_char_nx = CR;
            end
          end
        end
        ST_BRK: begin
          w_state_nx = ST_IDLE;
          if (data == PS2_LSHIFT) w_shift_l_nx = 1'b0;
          if (data == PS2_RSHIFT) w_shift_r_nx = 1'b0;
          if (data == PS2_CAPS)   w_caps_held_nx = 1'b0;
        end
        ST_EXT_BRK: w_state_nx = ST_IDLE;
        default:    w_state_nx = ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk50  (clk50),
    .reset  (reset),
    .i_push (r_emit),
    .i_data (r_char),
    .i_pop  (out_rdy),
    .o_valid(out_vld),
    .o_data (out_char),
    .o_full (w_full),
    .o_drop (w_drop)
  );

  assign overflow = r_overflow;
  assign caps_led = r_caps;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed and randomized checks of the scan-code decoder against a
// keystroke-level reference model with an expected-character queue.
module tb_ps2_scancode_decoder;

  logic       reset;
  logic       clk50;
  logic       vld;
  logic [7:0] data;
  logic       out_rdy;
  logic       out_vld;
  logic [7:0] out_char;
  logic       overflow;
  logic       caps_led;

  ps2_scancode_decoder #(.FIFO_DEPTH(4)) dut (
    .reset   (reset),
    .clk50   (clk50),
    .vld     (vld),
    .data    (data),
    .out_rdy (out_rdy),
    .out_vld (out_vld),
    .out_char(out_char),
    .overflow(overflow),
    .caps_led(caps_led)
  );

  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned ovf_seen = 0;

  always @(negedge clk50) if (overflow === 1'b1) ovf_seen++;

  // Reference model: prefix flags, modifier flags and the expected FIFO contents
  logic [7:0]  q[$];
  bit          m_ext, m_brk, m_shl, m_shr, m_caps, m_held;
  int unsigned m_drops = 0;

  logic [7:0] let_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] dig_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45};
  string dig_plain = "1234567890";
  string dig_shift = "!@#$%^&*()";
  logic [7:0] pool [20] = '{8'h1C, 8'h32, 8'h1A, 8'h15, 8'h16, 8'h45, 8'h3E, 8'h12,
    8'h59, 8'h58, 8'hF0, 8'hF0, 8'hE0, 8'h5A, 8'h29, 8'h66, 8'hAA, 8'h07, 8'hF0, 8'h1C};

  task automatic m_emit(input logic [7:0] c);
    if (q.size() < 4) q.push_back(c);
    else m_drops++;
  endtask

  task automatic m_make(input logic [7:0] b);
    bit sh;
    sh = m_shl | m_shr;
    if (b == 8'h12) m_shl = 1'b1;
    else if (b == 8'h59) m_shr = 1'b1;
    else if (b == 8'h58) begin
      if (!m_held) m_caps = !m_caps;
      m_held = 1'b1;
    end
    else if (b == 8'h29) m_emit(8'h20);
    else if (b == 8'h5A) m_emit(8'h0D);
    else if (b == 8'h66) m_emit(8'h08);
    else begin
      for (int i = 0; i < 26; i++)
        if (let_codes[i] == b) m_emit(8'(((sh ^ m_caps) ? "A" : "a") + i));
      for (int i = 0; i < 10; i++)
        if (dig_codes[i] == b) m_emit(sh ? dig_shift[i] : dig_plain[i]);
    end
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (m_brk) begin
      if (!m_ext) begin
        if (b == 8'h12) m_shl = 1'b0;
        if (b == 8'h59) m_shr = 1'b0;
        if (b == 8'h58) m_held = 1'b0;
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_ext) begin
      if (b == 8'h5A) m_emit(8'h0D);
      m_ext = 1'b0;
    end
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (b inside {8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE}) ;
    else m_make(b);
  endtask

  task automatic m_reset();
    q.delete();
    m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0; m_caps = 0; m_held = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_vld"},  32'(out_vld), 32'(q.size() != 0));
    check({tag, "_char"}, 32'(out_char), (q.size() != 0) ? 32'(q[0]) : 32'h0);
    check({tag, "_caps"}, 32'(caps_led), 32'(m_caps));
    check({tag, "_ovf"},  ovf_seen, m_drops);
  endtask

  task automatic send(input logic [7:0] b, input int unsigned hold, input int unsigned gap);
    @(negedge clk50);
    data = b;
    vld  = 1'b1;
    repeat (hold) @(negedge clk50);
    vld = 1'b0;
    repeat (gap) @(negedge clk50);
    m_byte(b);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 1, 3);
  endtask

  task automatic tap(input logic [7:0] b);
    key(b); key(8'hF0); key(b);
  endtask

  task automatic drain(input string tag);
    int unsigned guard = 0;
    while (q.size() != 0 && guard < 8) begin
      check({tag, "_head"}, 32'(out_char), 32'(q[0]));
      out_rdy = 1'b1;
      @(negedge clk50);
      out_rdy = 1'b0;
      void'(q.pop_front());
      guard++;
    end
    check({tag, "_empty"}, 32'(out_vld), 32'h0);
    check({tag, "_zero"},  32'(out_char), 32'h0);
  endtask

  initial begin
    reset = 1'b0; vld = 1'b0; data = '0; out_rdy = 1'b0;
    m_reset();
    repeat (3) @(negedge clk50);
    check("rst_vld", 32'(out_vld), 32'h0);
    check("rst_char", 32'(out_char), 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_caps", 32'(caps_led), 32'h0);
    reset = 1'b1;
    repeat (2) @(negedge clk50);

    // First-character latency: visible after the second edge, not the first
    @(negedge clk50); data = 8'h1C; vld = 1'b1;
    @(negedge clk50); check("lat_t0_vld", 32'(out_vld), 32'h0); vld = 1'b0;
    @(negedge clk50); check("lat_t1_vld", 32'(out_vld), 32'h1);
    check("lat_t1_char", 32'(out_char), 32'h61);
    m_byte(8'h1C);
    key(8'hF0); key(8'h1C);
    check_state("press_a");
    drain("press_a");

    key(8'h12); tap(8'h1C); key(8'hF0); key(8'h12);
    check_state("shift_a");
    drain("shift_a");

    tap(8'h58); tap(8'h1C);
    check_state("caps_a");
    key(8'h12); tap(8'h1C); key(8'hF0); key(8'h12);
    check_state("caps_shift_a");
    drain("caps");
    key(8'h58); key(8'h58); key(8'h58); key(8'hF0); key(8'h58);
    check_state("caps_repeat");

    key(8'hE0); key(8'h5A);
    key(8'hE0); key(8'h75); key(8'hE0); key(8'hF0); key(8'h75);
    key(8'hAA);
    check_state("ext");
    drain("ext");

    send(8'h1C, 1000, 3);
    key(8'hF0); key(8'h1C);
    check_state("held_vld");
    drain("held_vld");

    tap(8'h16); tap(8'h1E); tap(8'h26); tap(8'h25); tap(8'h2E);
    check_state("ovf");
    repeat (20) @(negedge clk50);
    check("stall_char", 32'(out_char), 32'h31);
    drain("ovf");

    tap(8'h32); tap(8'h21); tap(8'h23); tap(8'h24);
    check_state("full");
    // Push lands in the same cycle as a pop of the full FIFO
    @(negedge clk50); data = 8'h1A; vld = 1'b1;
    @(negedge clk50); vld = 1'b0; out_rdy = 1'b1;
    @(negedge clk50); out_rdy = 1'b0;
    repeat (2) @(negedge clk50);
    void'(q.pop_front());
    m_byte(8'h1A);
    key(8'hF0); key(8'h1A);
    check_state("push_pop_full");
    drain("push_pop_full");

    for (int n = 0; n < 60; n++) begin
      send(pool[$urandom_range(0, 19)], $urandom_range(1, 4), $urandom_range(2, 4));
      check_state("rand");
      if (n % 8 == 7) drain("rand");
    end
    drain("rand_end");

    key(8'hF0);
    @(negedge clk50); reset = 1'b0;
    @(negedge clk50); reset = 1'b1;
    m_reset();
    key(8'h1C);
    check_state("rst_mid_brk");
    drain("rst_mid_brk");

    tap(8'h58); key(8'h1C);
    check_state("pre_rst");
    @(negedge clk50); #1 reset = 1'b0;
    #1;
    check("async_rst_vld", 32'(out_vld), 32'h0);
    check("async_rst_caps", 32'(caps_led), 32'h0);
    @(negedge clk50); reset = 1'b1;
    m_reset();
    repeat (2) @(negedge clk50);
    check_state("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
